// File: rtl/alu_mdu.sv
// alu_mdu: single-issue integer unit. Logic/compare/add ops finish in one
// cycle. mul (shift-add) and divu/remu (restoring division) iterate one bit
// per cycle. The result is held in DONE until the consumer takes it.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. A result is consumed
// on a rising edge where out_valid and out_ready are both high. out_valid is
// high only in DONE. Neither side may withdraw anything once it is offered.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // acc : mul accumulator / div partial remainder
    // sh  : mul multiplier (shifts right) / div dividend turning into quotient
    // opnd: mul multiplicand (shifts left) / div divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opnd;
    logic             is_rem;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_iter;
    logic             load_res;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DIV);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Single-cycle results; slt uses a true signed compare so overflow of a-b
    // cannot flip the answer. Reserved opcodes give zero.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and of restoring division.
    // The remainder stays below the divisor, so the trial subtraction's top
    // bit is a clean borrow flag.
    always_comb begin
        mul_sum     = acc + (sh[0] ? opnd : '0);
        div_shift   = {acc, sh[WIDTH-1]};
        div_trial   = div_shift - {1'b0, opnd};
        div_ok      = ~div_trial[WIDTH];
        div_rem_nxt = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nxt = {sh[WIDTH-2:0], div_ok};
    end

    // Next-state logic; load_res marks every transition into DONE.
    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        load_val  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MUL: state_nxt = MUL;
                        OP_DIVU, OP_REMU: begin
                            if (b == '0) begin
                                state_nxt = DONE;
                                load_res  = 1'b1;
                                load_val  = (op == OP_DIVU) ? '1 : a;
                            end else begin
                                state_nxt = DIV;
                            end
                        end
                        default: begin
                            state_nxt = DONE;
                            load_res  = 1'b1;
                            load_val  = alu_res;
                        end
                    endcase
                end
            end
            MUL: begin
                if (last_iter) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    load_val  = mul_sum;
                end
            end
            DIV: begin
                if (last_iter) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    load_val  = is_rem ? div_rem_nxt : div_quo_nxt;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Result register and iterative datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            sh     <= '0;
            opnd   <= '0;
            is_rem <= 1'b0;
        end else begin
            if (load_res) begin
                result <= load_val;
                zero   <= (load_val == '0);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= '0;
                        is_rem <= (op == OP_REMU);
                        if (op == OP_MUL) begin
                            sh   <= b;
                            opnd <= a;
                        end else begin
                            sh   <= a;
                            opnd <= b;
                        end
                    end
                end
                MUL: begin
                    acc  <= mul_sum;
                    sh   <= sh >> 1;
                    opnd <= opnd << 1;
                    cnt  <= last_iter ? '0 : cnt + CNT_W'(1);
                end
                DIV: begin
                    acc <= div_rem_nxt;
                    sh  <= div_quo_nxt;
                    cnt <= last_iter ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu (WIDTH = 32).
module tb_alu_mdu;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] e;
    int           lat;
  } vec_t;

  alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Presents one operation on the accept edge, then scrambles the idle inputs.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom_range(0, 15));
  endtask

  // Waits for out_valid; cyc = cycle index after the accept cycle (1 = next cycle).
  task automatic wait_valid(output int cyc, output int bcnt, output logic got);
    cyc = 1;
    bcnt = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    got = (out_valid === 1'b1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b state=%0d, want 0 1 0 0",
               out_valid, in_ready, busy, dbg_state);
    end
    n_vec++;
    if (result !== '0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL reset_result: got result=%h zero=%b, want 0 1", result, zero);
    end
  endtask

  task automatic test_add_wrap();
    int cyc;
    int bcnt;
    logic got;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || cyc != 1) begin
      n_err++;
      $display("FAIL add_latency: got valid=%b at cycle %0d, want valid at cycle 1", got, cyc);
    end
    n_vec++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL add_wrap: got result=%h zero=%b, want 00000000 1", result, zero);
    end
    release_result();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL add_release: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  // Table of single-cycle, multi-cycle and divide-by-zero operations, issued back to back.
  task automatic test_back_to_back();
    vec_t tbl[$];
    int cyc;
    int bcnt;
    logic got;
    tbl.push_back('{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1});
    tbl.push_back('{OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1});
    tbl.push_back('{OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1});
    tbl.push_back('{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1});
    tbl.push_back('{OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1});
    tbl.push_back('{OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1});
    tbl.push_back('{OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1});
    tbl.push_back('{OP_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1});
    tbl.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1});
    tbl.push_back('{OP_SLT,  32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1});
    tbl.push_back('{4'b1010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1});
    tbl.push_back('{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    tbl.push_back('{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
    tbl.push_back('{OP_MUL,  32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 33});
    tbl.push_back('{OP_MUL,  32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33});
    tbl.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33});
    tbl.push_back('{OP_REMU, 32'h0000_0007, 32'h0000_0064, 32'h0000_0007, 33});
    tbl.push_back('{OP_DIVU, 32'h0000_0005, 32'h0000_000A, 32'h0000_0000, 33});
    tbl.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33});
    tbl.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33});
    tbl.push_back('{OP_DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1});
    tbl.push_back('{OP_REMU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1});
    foreach (tbl[i]) begin
      send(tbl[i].o, tbl[i].x, tbl[i].y);
      wait_valid(cyc, bcnt, got);
      n_vec++;
      if (got !== 1'b1 || cyc != tbl[i].lat) begin
        n_err++;
        $display("FAIL b2b_latency[%0d] op=%b: got valid=%b at cycle %0d, want cycle %0d",
                 i, tbl[i].o, got, cyc, tbl[i].lat);
      end
      n_vec++;
      if (result !== tbl[i].e || zero !== (tbl[i].e == '0)) begin
        n_err++;
        $display("FAIL b2b_result[%0d] op=%b a=%h b=%h: got %h zero=%b, want %h zero=%b",
                 i, tbl[i].o, tbl[i].x, tbl[i].y, result, zero, tbl[i].e, (tbl[i].e == '0));
      end
      release_result();
    end
  endtask

  task automatic test_mul();
    int cyc;
    int bcnt;
    logic got;
    send(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL mul_enter: got busy=%b ready=%b state=%0d, want 1 0 1", busy, in_ready, dbg_state);
    end
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || cyc != 33 || bcnt != 32) begin
      n_err++;
      $display("FAIL mul_timing: got valid=%b at cycle %0d busy=%0d cycles, want cycle 33 busy 32",
               got, cyc, bcnt);
    end
    n_vec++;
    if (result !== 32'h000B_000F || zero !== 1'b0) begin
      n_err++;
      $display("FAIL mul_result: got %h zero=%b, want 000b000f 0", result, zero);
    end
    release_result();
  endtask

  task automatic test_div();
    int cyc;
    int bcnt;
    logic got;
    send(OP_DIVU, 32'd100, 32'd7);
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || cyc != 33 || bcnt != 32) begin
      n_err++;
      $display("FAIL divu_timing: got valid=%b at cycle %0d busy=%0d, want cycle 33 busy 32",
               got, cyc, bcnt);
    end
    n_vec++;
    if (result !== 32'd14) begin
      n_err++;
      $display("FAIL divu_result: got %0d, want 14", result);
    end
    release_result();
    send(OP_REMU, 32'd100, 32'd7);
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || result !== 32'd2) begin
      n_err++;
      $display("FAIL remu_result: got valid=%b result=%0d, want 1 2", got, result);
    end
    release_result();
    send(OP_DIVU, 32'd55, 32'd0);
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || cyc != 1 || bcnt != 0 || result !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL divu_by_zero: got valid=%b cycle %0d busy=%0d result=%h, want cycle 1 busy 0 ffffffff",
               got, cyc, bcnt, result);
    end
    release_result();
  endtask

  // Result held under back-pressure; in_ready returns only after the take.
  task automatic test_backpressure();
    int cyc;
    int bcnt;
    int bad;
    logic got;
    send(OP_SUB, 32'd5, 32'd5);
    wait_valid(cyc, bcnt, got);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (got !== 1'b1 || bad != 0) begin
      n_err++;
      $display("FAIL hold_stable: got valid=%b and %0d unstable cycles, want 1 and 0", got, bad);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_take_cycle: got ready=%b valid=%b, want 0 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL hold_after_take: got ready=%b valid=%b result=%h zero=%b, want 1 0 0 1",
               in_ready, out_valid, result, zero);
    end
  endtask

  // in_valid during MUL is ignored; out_ready in IDLE does nothing; result holds in IDLE.
  task automatic test_ignore();
    int cyc;
    int bcnt;
    int bad;
    logic got;
    send(OP_MUL, 32'd9, 32'd11);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
      in_valid = 1'b1;
      op = OP_ADD;
      a = 32'd1;
      b = 32'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || bad != 0 || result !== 32'd99) begin
      n_err++;
      $display("FAIL ignore_busy: got valid=%b ready_high=%0d result=%0d, want 1 0 99",
               got, bad, result);
    end
    release_result();
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd99 || zero !== 1'b0) bad++;
    end
    out_ready = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle_hold: got %0d disturbed idle cycles, want 0", bad);
    end
  endtask

  // Reset mid-mul aborts it, then the unit works normally.
  task automatic test_reset_abort();
    int cyc;
    int bcnt;
    int bad;
    logic got;
    send(OP_MUL, 32'h1234_5678, 32'h0000_0003);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL abort_state: got ready=%b busy=%b valid=%b result=%h zero=%b, want 1 0 0 0 1",
               in_ready, busy, out_valid, result, zero);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_no_result: got %0d cycles with valid/busy, want 0", bad);
    end
    send(OP_ADD, 32'd2, 32'd3);
    wait_valid(cyc, bcnt, got);
    n_vec++;
    if (got !== 1'b1 || cyc != 1 || result !== 32'd5) begin
      n_err++;
      $display("FAIL abort_then_add: got valid=%b cycle %0d result=%0d, want cycle 1 result 5",
               got, cyc, result);
    end
    release_result();
  endtask

  // Reset beats a result handshake and an accept on the same edge.
  task automatic test_reset_priority();
    int cyc;
    int bcnt;
    logic got;
    send(OP_ADD, 32'd1, 32'd1);
    wait_valid(cyc, bcnt, got);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (got !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL rst_vs_take: got valid=%b result=%h zero=%b, want 0 0 1", out_valid, result, zero);
    end
    in_valid = 1'b1;
    op = OP_ADD;
    a = 32'd4;
    b = 32'd4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      n_err++;
      $display("FAIL rst_vs_accept: got valid=%b ready=%b result=%h, want 0 1 0",
               out_valid, in_ready, result);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_wrap();
    test_mul();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_ignore();
    test_reset_abort();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL support any value 8..64.
REQ-002 Parameter CNT_W, default 6, iteration-counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  unit can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  4  opcode: 0000 add, 0001 sub, 0010 slt signed, 0011 or, 0100 and, 0101 xor, 0110 sltu, 0111 mul (low WIDTH bits), 1000 divu, 1001 remu, other codes reserved.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  high when result is all zeros; registered with result.
REQ-014 busy  output  1  high in MUL or DIV state.

Function
REQ-015 Accept SHALL occur on a rising edge where in_valid and in_ready are both high; a, b and op SHALL be captured at that edge.
REQ-016 in_ready SHALL be high only in state IDLE.
REQ-017 States SHALL be IDLE, MUL, DIV, DONE; IDLE->DONE on accept of a single-cycle op, IDLE->MUL on accept of mul, IDLE->DIV on accept of divu/remu with b != 0, IDLE->DONE on divu/remu with b == 0.
REQ-018 Single-cycle ops (add, sub, slt, or, and, xor, sltu, reserved) SHALL load result at the accept edge; out_valid SHALL be high the following cycle (latency 1).
REQ-019 add/sub SHALL wrap modulo 2**WIDTH; carry and overflow are discarded.
REQ-020 slt SHALL return 1 if signed(a) < signed(b) else 0, computed correctly under overflow (not from sum sign bit alone); sltu the unsigned equivalent; upper WIDTH-1 bits zero.
REQ-021 Reserved opcodes SHALL return all zeros with zero = 1.
REQ-022 mul SHALL be iterative shift-add, one multiplier bit per cycle, WIDTH iterations in MUL; MUL->DONE after the last iteration; out_valid first high WIDTH+1 cycles after accept.
REQ-023 divu/remu SHALL be iterative restoring division, one quotient bit per cycle, WIDTH iterations in DIV; DIV->DONE after the last; out_valid first high WIDTH+1 cycles after accept.
REQ-024 divu with b == 0 SHALL return all ones; remu with b == 0 SHALL return a; both with latency 1.
REQ-025 In DONE, out_valid SHALL be high and result/zero stable until a cycle with out_ready high; DONE->IDLE on that edge, out_valid low the next cycle.
REQ-026 result and zero SHALL hold their last value in IDLE; they SHALL change only on a transition into DONE.
REQ-027 in_valid while not in_ready SHALL be ignored; inputs are not sampled outside accept edges.
REQ-028 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-029 rst high at a rising edge SHALL force state IDLE, result = 0, zero = 1, out_valid = 0, busy = 0, iteration counter = 0, in any state.
REQ-030 rst asserted during MUL or DIV SHALL abort the operation with no result produced; in_ready SHALL be high the cycle after rst deasserts.
REQ-031 rst SHALL take priority over a simultaneous accept or result handshake.

Verification
REQ-032 WIDTH=32, op=add, a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0, zero=1.
REQ-033 op=slt, a=0x80000000, b=0x00000001 -> result=1; same with op=sltu -> result=0.
REQ-034 op=mul, a=0x00010003, b=0x00020005, out_ready=1 -> out_valid first high 33 cycles after accept, result=0x000B000F, busy high for 32 cycles.
REQ-035 op=divu a=100 b=7 -> result=14; op=remu same operands -> result=2; op=divu b=0 -> result=0xFFFFFFFF after 1 cycle.
REQ-036 op=sub a=5 b=5 with out_ready=0 for 4 cycles -> out_valid and result=0, zero=1 held stable 4 cycles, in_ready low until the cycle after out_ready rises.
REQ-037 rst pulsed at cycle 10 of a mul -> no out_valid, result=0, in_ready=1 after reset; a following add 2+3 returns 5.
